// File: rtl/csr_timer_bank_pkg.sv
`default_nettype none
// ============================================================================
// Module   : timer_pkg
// Purpose  : Shared register offsets, TCFG field positions and the TCFG view
//            used by the CSR timer bank and its per-channel timers.
// Revision : 1.0 - initial release
// ============================================================================
package timer_pkg;

    // Register offsets inside one channel's four-word window
    localparam logic [1:0] TCFG_OFF  = 2'd0;
    localparam logic [1:0] TVAL_OFF  = 2'd1;
    localparam logic [1:0] TICLR_OFF = 2'd2;

    // TCFG bit positions
    localparam int TCFG_EN       = 0;
    localparam int TCFG_PERIODIC = 1;

    // TCFG laid out as a full 32-bit word; narrower timers zero-extend into it
    typedef struct packed {
        logic [29:0] initval;
        logic        periodic;
        logic        en;
    } timer_cfg_t;

endpackage
`default_nettype wire

// File: rtl/csr_timer_bank_chan.sv
`default_nettype none
// ============================================================================
// Module   : timer_chan
// Purpose  : One down-count timer channel: TCFG, TVAL and interrupt pending.
// Revision : 1.0 - initial release
// ============================================================================
module timer_chan
    import timer_pkg::*;
#(
    parameter int TW = 32
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          tick,      // prescaler tick, already gated by halt
    input  logic          cfg_we,    // TCFG write to this channel
    input  logic          clr,       // effective TICLR bit0 write
    input  logic [TW-1:0] wr_data,
    input  logic [TW-1:0] wr_mask,   // effective mask (all-ones for full write)
    output logic [TW-1:0] cfg,
    output logic [TW-1:0] tval,
    output logic          pending
);

    logic [TW-1:0] r_cfg;
    logic [TW-1:0] r_tval;
    logic          r_pending;

    timer_cfg_t    w_cfg;
    logic [TW-1:0] w_cfg_new;
    logic [TW-1:0] w_new_load;
    logic [TW-1:0] w_reload;
    logic          w_step;
    logic          w_expire;
    logic          w_unused_cfg;

    assign w_cfg        = timer_cfg_t'(32'(r_cfg));
    assign w_cfg_new    = (wr_data & wr_mask) | (r_cfg & ~wr_mask);
    assign w_new_load   = {w_cfg_new[TW-1:2], 2'b00};
    assign w_reload     = {w_cfg.initval[TW-3:0], 2'b00};
    assign w_step       = tick & r_cfg[TCFG_EN] & (r_tval != '0);
    assign w_expire     = w_step & (r_tval == TW'(1));
    assign w_unused_cfg = ^w_cfg;

    // Configuration/count update; a TCFG write overrides decrement and reload,
    // while expiry always wins over a same-cycle pending clear
    always_ff @(posedge clk) begin
        if (reset) begin
            r_cfg     <= '0;
            r_tval    <= '0;
            r_pending <= 1'b0;
        end else begin
            if (cfg_we) begin
                r_cfg  <= w_cfg_new;
                r_tval <= w_new_load;
            end else if (w_step) begin
                if (w_expire)
                    r_tval <= r_cfg[TCFG_PERIODIC] ? w_reload : '0;
                else
                    r_tval <= r_tval - TW'(1);
            end
            if (w_expire)
                r_pending <= 1'b1;
            else if (clr)
                r_pending <= 1'b0;
        end
    end

    assign cfg     = r_cfg;
    assign tval    = r_tval;
    assign pending = r_pending;

endmodule
`default_nettype wire

// File: rtl/csr_timer_bank.sv
`default_nettype none
// ============================================================================
// Module   : csr_timer_bank
// Purpose  : NCH-channel CSR timer bank with shared prescaler, debug-halt
//            freeze and the 64-bit stable counter read by rdcnt.
// Revision : 1.0 - initial release
// ============================================================================
module csr_timer_bank
    import timer_pkg::*;
#(
    parameter int NCH = 2,
    parameter int TW  = 32,
    parameter int DIV = 1,
    localparam int AW = $clog2(NCH) + 2
) (
    input  logic           clk,
    input  logic           reset,
    input  logic [AW-1:0]  csr_addr,
    input  logic           csr_we,
    input  logic           csr_me,
    input  logic [31:0]    csr_mask,
    input  logic [31:0]    csr_wdata,
    output logic [31:0]    csr_rdata,
    input  logic           halt,
    output logic [NCH-1:0] irq_pending,
    output logic           irq_any,
    output logic [31:0]    counter_hi,
    output logic [31:0]    counter_lo
);

    localparam int PW = (DIV > 1) ? $clog2(DIV) : 1;

    logic [PW-1:0]  r_presc;
    logic [63:0]    r_stable;
    logic           w_presc_last;
    logic           w_tick;
    logic [3:0]     w_chan_idx;
    logic [1:0]     w_reg;
    logic [31:0]    w_mask;
    logic           w_unused;

    logic [TW-1:0]  w_cfg  [NCH];
    logic [TW-1:0]  w_tval [NCH];
    logic [NCH-1:0] w_pending;

    assign w_presc_last = (r_presc == PW'(DIV - 1));
    assign w_tick       = w_presc_last & ~halt;
    assign w_reg        = csr_addr[1:0];
    assign w_mask       = csr_me ? csr_mask : 32'hFFFF_FFFF;
    assign w_unused     = ^{csr_wdata, w_mask};

    // A single-channel bank has no channel field in the address
    generate
        if (NCH > 1) begin : g_chan_idx
            assign w_chan_idx = 4'(csr_addr[AW-1:2]);
        end else begin : g_chan_idx_single
            assign w_chan_idx = 4'd0;
        end
    endgenerate

    // Prescaler: counts 0..DIV-1, frozen while halted
    always_ff @(posedge clk) begin
        if (reset)
            r_presc <= '0;
        else if (!halt)
            r_presc <= w_presc_last ? '0 : r_presc + PW'(1);
    end

    // Stable counter: free-running every clock unless halted
    always_ff @(posedge clk) begin
        if (reset)
            r_stable <= '0;
        else if (!halt)
            r_stable <= r_stable + 64'd1;
    end

    generate
        for (genvar i = 0; i < NCH; i++) begin : g_chan
            logic w_sel;
            assign w_sel = csr_we & (w_chan_idx == 4'(i));

            timer_chan #(
                .TW (TW)
            ) u_chan (
                .clk     (clk),
                .reset   (reset),
                .tick    (w_tick),
                .cfg_we  (w_sel & (w_reg == TCFG_OFF)),
                .clr     (w_sel & (w_reg == TICLR_OFF) & csr_wdata[0] & w_mask[0]),
                .wr_data (csr_wdata[TW-1:0]),
                .wr_mask (w_mask[TW-1:0]),
                .cfg     (w_cfg[i]),
                .tval    (w_tval[i]),
                .pending (w_pending[i])
            );
        end
    endgenerate

    // Read mux: TCFG and TVAL zero-extended; TICLR, reserved and absent channels read 0
    always_comb begin
        csr_rdata = '0;
        for (int i = 0; i < NCH; i++) begin
            if (w_chan_idx == 4'(i)) begin
                if (w_reg == TCFG_OFF)
                    csr_rdata = 32'(w_cfg[i]);
                else if (w_reg == TVAL_OFF)
                    csr_rdata = 32'(w_tval[i]);
            end
        end
    end

    assign irq_pending = w_pending;
    assign irq_any     = |w_pending;
    assign counter_hi  = r_stable[63:32];
    assign counter_lo  = r_stable[31:0];

endmodule
`default_nettype wire

// File: doc/csr_timer_bank.md
Name: csr_timer_bank

Overview:
- Parametrised successor to the single-channel LoongArch CSR timer (TCFG/TVAL/TICLR).
- Provides NCH independent down-count timers of width TW, a shared clock prescaler and a debug-halt freeze.
- Also provides the 64-bit stable counter used by rdcnt.
- Sits beside the CSR file; the CSR decode forwards timer-window accesses here, and irq_pending feeds ESTAT.IS[11] (channel 0) and the platform interrupt lines.

Parameters:
- NCH, 2, number of timer channels (1..8).
- TW, 32, timer width in bits (4..32); InitVal field is TCFG[TW-1:2].
- DIV, 1, prescaler ratio (>=1); timers decrement once every DIV clocks.
- AW, $clog2(NCH)+2 (localparam, derived), local address width.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- csr_addr  in  AW  {channel, reg}; reg 0=TCFG, 1=TVAL (RO), 2=TICLR (W1C), 3=reserved.
- csr_we  in  1  write strobe.
- csr_me  in  1  masked write (csrxchg); 0 means full write.
- csr_mask  in  32  write mask, used when csr_me=1.
- csr_wdata  in  32  write data.
- csr_rdata  out  32  combinational read data.
- halt  in  1  debug freeze of prescaler, timers and stable counter.
- irq_pending  out  NCH  registered per-channel timer interrupt pending.
- irq_any  out  1  OR of irq_pending (combinational from registers).
- counter_hi  out  32  stable counter [63:32].
- counter_lo  out  32  stable counter [31:0].

Behaviour:
- Reset (reset=1 at a clk edge) clears all TCFG, TVAL, pending, prescaler and stable counter to 0. csr_rdata follows reset state.
- Effective write: m = csr_me ? csr_mask : all-ones; new = (wdata & m) | (old & ~m). Bits at or above TW are not stored.
- TCFG: bit0 En, bit1 Periodic, [TW-1:2] InitVal.
  - A TCFG write updates TCFG and loads TVAL <= {new InitVal, 2'b00} at the same edge.
  - The write takes precedence over any decrement or reload that cycle.
- TICLR: a write with effective bit0=1 clears pending at the edge. TICLR reads return 0.
- TVAL: writes are ignored. Reads return the current count, zero-extended.
- Reserved reg and channel index >= NCH: writes ignored, reads 0.
- Prescaler:
  - presc counts 0..DIV-1 while halt=0.
  - tick=1 in the cycle presc==DIV-1; presc then wraps to 0.
  - DIV=1 gives tick every cycle.
  - presc holds while halt=1.
- Channel step, only when tick=1, halt=0, En=1, TVAL!=0:
  - TVAL==1: pending <= 1. If Periodic, TVAL <= {InitVal,2'b00}; otherwise TVAL <= 0 and the channel stops.
  - Otherwise TVAL <= TVAL-1.
  - Periodic with InitVal=0 reloads 0, so the channel stops after one expiry.
- En=0 or TVAL==0: TVAL holds.
- Simultaneous TICLR clear and expiry on one channel: expiry wins, pending stays 1.
- TCFG write coinciding with expiry: TCFG/TVAL take the written values, and pending is still set.
- Stable counter: +1 every clk while halt=0, wrapping modulo 2^64. It is not affected by the prescaler or by CSR writes.
- halt asserted mid-count: all state freezes exactly. CSR writes and TICLR clears remain effective during halt.
- Latency: a write is visible on csr_rdata the cycle after csr_we. An expiry is visible on irq_pending the cycle after the TVAL==1 tick.

Decomposition:
- Shared package timer_pkg holds:
  - register offsets TCFG_OFF=0, TVAL_OFF=1, TICLR_OFF=2;
  - field positions TCFG_EN=0, TCFG_PERIODIC=1;
  - typedef timer_cfg_t (en, periodic, initval).
- One sub-module, timer_chan: holds one channel's TCFG/TVAL/pending; instantiated NCH times by generate.
- Prescaler, address decode, read mux and stable counter stay in the top.

Test Plan:
- One-shot: DIV=1; write ch0 TCFG=0x0000_0009 (En=1, InitVal=2) -> TVAL reads 8,7,..,1,0; irq_pending[0] rises the cycle after TVAL==1 and stays; TVAL holds 0.
- Periodic with DIV=4, TW=32: write ch1 TCFG=0x7 (InitVal=1) -> TVAL decrements every 4 clocks from 4; expiry sets irq_pending[1]; TVAL reloads 4; TICLR write 0x1 clears pending, and it sets again at the next expiry.
- Clear/expiry collision: TICLR write lands in the TVAL==1 tick cycle -> pending remains 1. The same clear one cycle later -> pending 0.
- Masked write: TCFG=0x0000_0015; csrxchg with mask=0x2, wdata=0x2 -> TCFG=0x17; TVAL reloads 0x14.
- Halt: assert halt for 10 cycles mid-count -> TVAL, presc and counter_lo unchanged. Release -> resume from the same values. A TICLR during halt still clears pending.
- Bounds and reset: a write to channel index NCH and reg 3 leaves state unchanged and reads 0. Counter near wrap (preloaded by force to 0xFFFF_FFFF low) carries into counter_hi. Reset mid-count returns all outputs to 0 next cycle.
